// File: rtl/keypad_pkg.sv
// Shared definitions for the 4x4 keypad scanner: register map, STATUS layout,
// key-code width, scan-FSM states and the lowest-set-key encoder.
package keypad_pkg;

  localparam logic [31:0] KP_STATUS_OFS = 32'd0;
  localparam logic [31:0] KP_DATA_OFS   = 32'd4;

  localparam int KP_ST_NEMPTY_BIT = 0;
  localparam int KP_ST_OVF_BIT    = 1;
  localparam int KP_ST_CNT_LSB    = 4;
  localparam int KP_ST_CNT_MSB    = 7;

  localparam int KEY_CODE_W = 4;
  localparam int KEY_NUM    = 16;

  typedef enum logic [2:0] {
    SCAN_IDLE,
    SCAN_ROW0,
    SCAN_ROW1,
    SCAN_ROW2,
    SCAN_ROW3
  } scan_state_t;

  // Code (row*4+col) of the lowest set bit; 0 when no bit is set.
  function automatic logic [KEY_CODE_W-1:0] lowest_key(input logic [KEY_NUM-1:0] keys);
    lowest_key = '0;
    for (int i = KEY_NUM - 1; i >= 0; i--) begin
      if (keys[i]) lowest_key = KEY_CODE_W'(i);
    end
  endfunction

endpackage

// File: rtl/keypad_fifo.sv
// Key-code FIFO: head visible combinationally, push/pop take effect on the clock edge.
// A push into a full FIFO is dropped unless a pop happens in the same cycle.
module keypad_fifo #(
  parameter  int DEPTH = 4,
  parameter  int W     = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [W-1:0]  push_dat,
  input  logic          pop,
  output logic [W-1:0]  pop_dat,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || pop);
  assign pop_dat = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: row strobing, debounced snapshots, new-press codes queued for bus reads.
// dout one cycle after readEnable; full FIFO drops codes and sets overflow; KEYPAD_IRQ_EN adds irq.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_FF10,
  parameter int          SCAN_DIV   = 2500,
  parameter int          DEBOUNCE   = 4,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [3:0]  rows,
  input  logic [3:0]  cols,
  input  logic [31:0] address,
  input  logic [31:0] din,
  input  logic        writeEnable,
  input  logic        readEnable,
  output logic [31:0] dout
`ifdef KEYPAD_IRQ_EN
  ,
  output logic        irq
`endif
);

  localparam int          CNT_W = $clog2(SCAN_DIV);
  localparam int          FCW   = $clog2(FIFO_DEPTH) + 1;
  localparam logic [3:0]  DEB   = 4'(DEBOUNCE);

  logic [3:0]            cols_s1, cols_s2, col_act;
  scan_state_t           state, state_nxt;
  logic [CNT_W-1:0]      row_cnt;
  logic                  row_last, scan_end;
  logic [1:0]            row_idx;
  logic [KEY_NUM-1:0]    snap, snap_new, last_snap, accepted, prev_accepted, acc_nxt, new_keys;
  logic [3:0]            stable, stable_nxt;
  logic                  key_push;
  logic [KEY_CODE_W-1:0] key_code, fifo_dat;
  logic                  fifo_full, fifo_empty;
  logic [FCW-1:0]        fifo_count;
  logic                  sel_status, sel_data, rd_pop, ovf, ovf_set, ovf_clr;
  logic [31:0]           status;
  logic                  din_unused;

  // Idle level of the pulled-up columns, so reset never looks like a press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cols_s1 <= 4'hF;
      cols_s2 <= 4'hF;
    end else begin
      cols_s1 <= cols;
      cols_s2 <= cols_s1;
    end
  end
  assign col_act = ~cols_s2;

  assign row_last = (state != SCAN_IDLE) && (row_cnt == CNT_W'(SCAN_DIV - 1));
  assign scan_end = row_last && (state == SCAN_ROW3);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= SCAN_IDLE;
      row_cnt <= '0;
    end else begin
      state   <= state_nxt;
      row_cnt <= (state == SCAN_IDLE || row_last) ? '0 : row_cnt + CNT_W'(1);
    end
  end

  always_comb begin
    state_nxt = state;
    rows      = 4'b1111;
    row_idx   = 2'd0;
    case (state)
      SCAN_IDLE: state_nxt = SCAN_ROW0;
      SCAN_ROW0: begin rows = 4'b1110; row_idx = 2'd0; if (row_last) state_nxt = SCAN_ROW1; end
      SCAN_ROW1: begin rows = 4'b1101; row_idx = 2'd1; if (row_last) state_nxt = SCAN_ROW2; end
      SCAN_ROW2: begin rows = 4'b1011; row_idx = 2'd2; if (row_last) state_nxt = SCAN_ROW3; end
      SCAN_ROW3: begin rows = 4'b0111; row_idx = 2'd3; if (row_last) state_nxt = SCAN_ROW0; end
      default:   state_nxt = SCAN_IDLE;
    endcase
  end

  always_comb begin
    snap_new = snap;
    snap_new[{row_idx, 2'b00} +: 4] = col_act;
    if (snap_new == last_snap) stable_nxt = (stable == DEB) ? stable : stable + 4'd1;
    else                       stable_nxt = 4'd1;
    acc_nxt  = (stable_nxt == DEB) ? snap_new : accepted;
    new_keys = acc_nxt & ~prev_accepted;
    key_push = scan_end && (|new_keys);
    key_code = lowest_key(new_keys);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snap          <= '0;
      last_snap     <= '0;
      stable        <= '0;
      accepted      <= '0;
      prev_accepted <= '0;
    end else begin
      if (row_last) snap <= snap_new;
      if (scan_end) begin
        last_snap     <= snap_new;
        stable        <= stable_nxt;
        accepted      <= acc_nxt;
        prev_accepted <= acc_nxt;
      end
    end
  end

  keypad_fifo #(.DEPTH(FIFO_DEPTH), .W(KEY_CODE_W)) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (key_push),
    .push_dat (key_code),
    .pop      (rd_pop),
    .pop_dat  (fifo_dat),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  assign sel_status = (address == BASE_ADDR + KP_STATUS_OFS);
  assign sel_data   = (address == BASE_ADDR + KP_DATA_OFS);
  assign rd_pop     = readEnable && sel_data && !fifo_empty;
  assign ovf_set    = key_push && fifo_full && !rd_pop;
  assign ovf_clr    = writeEnable && sel_status && din[KP_ST_OVF_BIT];
  assign din_unused = ^{din[31:2], din[0]};

  always_comb begin
    status = '0;
    status[KP_ST_NEMPTY_BIT]            = !fifo_empty;
    status[KP_ST_OVF_BIT]               = ovf;
    status[KP_ST_CNT_MSB:KP_ST_CNT_LSB] = 4'(fifo_count);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf  <= 1'b0;
      dout <= '0;
    end else begin
      if (ovf_set)      ovf <= 1'b1;
      else if (ovf_clr) ovf <= 1'b0;
      if (readEnable) begin
        if (sel_status)                  dout <= status;
        else if (sel_data && !fifo_empty) dout <= {{(31-KEY_CODE_W){1'b0}}, 1'b1, fifo_dat};
        else                             dout <= '0;
      end
    end
  end

`ifdef KEYPAD_IRQ_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) irq <= 1'b0;
    else        irq <= !fifo_empty || ovf;
  end
`endif

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner with SCAN_DIV=4, DEBOUNCE=3, FIFO_DEPTH=4.
module tb_keypad_scanner;

  localparam logic [31:0] BASE = 32'h0000_FF10;
  localparam logic [31:0] ST   = BASE;
  localparam logic [31:0] DT   = BASE + 32'd4;
  localparam int          SCAN = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  rows, cols;
  logic [31:0] address, din, dout;
  logic        writeEnable, readEnable;
`ifdef KEYPAD_IRQ_EN
  logic        irq;
`endif
  logic [15:0] keys;

  keypad_scanner #(.BASE_ADDR(BASE), .SCAN_DIV(4), .DEBOUNCE(3), .FIFO_DEPTH(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rows        (rows),
    .cols        (cols),
    .address     (address),
    .din         (din),
    .writeEnable (writeEnable),
    .readEnable  (readEnable),
    .dout        (dout)
`ifdef KEYPAD_IRQ_EN
    ,
    .irq         (irq)
`endif
  );

  always #5 clk = ~clk;

  // Keypad model: a pressed key shorts its column low while its row is strobed.
  always_comb begin
    cols = 4'hF;
    for (int r = 0; r < 4; r++) begin
      if (!rows[r]) cols = ~keys[4*r +: 4];
    end
  end

  int checks = 0;
  int passes = 0;
  logic [31:0] exp_q[$];
  bit          exp_ovf;

  typedef struct {
    logic [15:0] keys;
    logic [31:0] exp_status;
    logic [31:0] exp_data;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    address = a; readEnable = 1'b1;
    @(negedge clk);
    readEnable = 1'b0;
    d = dout;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] v);
    address = a; din = v; writeEnable = 1'b1;
    @(negedge clk);
    writeEnable = 1'b0;
  endtask

  function automatic logic [31:0] exp_status();
    logic [31:0] s;
    s      = '0;
    s[7:4] = 4'(exp_q.size());
    s[1]   = exp_ovf;
    s[0]   = (exp_q.size() != 0);
    return s;
  endfunction

  function automatic void model_push(input logic [31:0] d);
    if (exp_q.size() < 4) exp_q.push_back(d);
    else exp_ovf = 1'b1;
  endfunction

  task automatic press(input logic [15:0] k, input logic [31:0] exp_d);
    keys = k;  tick(6 * SCAN);
    keys = '0; tick(6 * SCAN);
    model_push(exp_d);
  endtask

  task automatic status_check(input string name);
    logic [31:0] d;
    bus_read(ST, d);
    check(name, d, exp_status());
  endtask

  task automatic data_check(input string name);
    logic [31:0] d, e;
    bus_read(DT, d);
    e = '0;
    if (exp_q.size() != 0) e = exp_q.pop_front();
    check(name, d, e);
  endtask

  task automatic wait_rows_edge(input logic [3:0] target, input string name);
    logic [3:0] prev;
    bit found;
    found = 1'b0;
    prev  = rows;
    for (int i = 0; i < 64 && !found; i++) begin
      @(negedge clk);
      if (rows == target && prev != target) found = 1'b1;
      prev = rows;
    end
    if (!found) begin
      checks++;
      $display("FAIL %s: rows=0x%0h, required a transition to 0x%0h within 64 cycles", name, rows, target);
    end
  endtask

  initial begin
    vec_t        vecs[6];
    logic [3:0]  rows_exp[17];
    logic [3:0]  one;
    logic [31:0] d;
    int          ovf_codes[5];

    vecs[0] = '{16'h0200, 32'h11, 32'h19};
    vecs[1] = '{16'h0001, 32'h11, 32'h10};
    vecs[2] = '{16'h8000, 32'h11, 32'h1F};
    vecs[3] = '{16'h0420, 32'h11, 32'h15};
    vecs[4] = '{16'h0400, 32'h11, 32'h1A};
    vecs[5] = '{16'h1008, 32'h11, 32'h13};
    ovf_codes = '{1, 2, 3, 4, 6};
    one = 4'b0001;
    rows_exp[0] = 4'hF;
    for (int i = 1; i < 17; i++) rows_exp[i] = ~(one << ((i - 1) / 4));

    rst_n = 1'b0; keys = '0; address = '0; din = '0; writeEnable = 1'b0; readEnable = 1'b0;
    exp_ovf = 1'b0;
    tick(3);
    check("rows_in_reset", {28'b0, rows}, 32'hF);
    check("dout_in_reset", dout, 32'h0);
`ifdef KEYPAD_IRQ_EN
    check("irq_in_reset", {31'b0, irq}, 32'h0);
`endif

    // Reset release: IDLE for one cycle, then each row held for SCAN_DIV cycles.
    rst_n = 1'b1;
    for (int i = 0; i < 17; i++) begin
      check($sformatf("rows_seq[%0d]", i), {28'b0, rows}, {28'b0, rows_exp[i]});
      @(negedge clk);
    end
    status_check("status_after_reset");

    // Single presses, including multi-key lowest-code selection.
    for (int i = 0; i < 6; i++) begin
      press(vecs[i].keys, vecs[i].exp_data);
      status_check($sformatf("vec%0d_status_model", i));
      bus_read(ST, d);
      check($sformatf("vec%0d_status", i), d, vecs[i].exp_status);
      data_check($sformatf("vec%0d_data", i));
      status_check($sformatf("vec%0d_status_drained", i));
    end

    // Bounce: key 0 toggles every scan, so no three snapshots in a row agree.
    keys = 16'h0001;
    for (int i = 0; i < 6; i++) begin
      tick(SCAN);
      keys[0] = ~keys[0];
    end
    keys = '0;
    tick(6 * SCAN);
    status_check("bounce_no_push");

    // Overflow: fifth press is dropped and sets the sticky flag.
    for (int i = 0; i < 5; i++) press(16'd1 << ovf_codes[i], 32'h10 | 32'(ovf_codes[i]));
    status_check("ovf_status");
    bus_write(DT, 32'h2);
    status_check("data_write_ignored");
    bus_read(BASE + 32'd8, d);
    check("unmapped_read", d, 32'h0);
    bus_write(ST, 32'h2);
    exp_ovf = 1'b0;
    status_check("ovf_cleared");

    // Push and DATA pop on the same edge while full: key 14 accepted at end of scan 3.
    wait_rows_edge(4'b1110, "row0_align");
    keys = 16'h4000;
    tick(47);
    bus_read(DT, d);
    check("pushpop_data", d, exp_q.size() != 0 ? exp_q.pop_front() : 32'h0);
    model_push(32'h1E);
    status_check("pushpop_status");
    keys = '0;
    tick(6 * SCAN);
    for (int i = 0; i < 4; i++) data_check($sformatf("drain%0d", i));
    data_check("empty_data");
    status_check("empty_status");

    // Reset during ROW2 with a key held: a full debounce is needed afterwards.
    keys = 16'h0200;
    wait_rows_edge(4'b1011, "row2_align");
    rst_n = 1'b0;
    tick(1);
    check("rows_mid_reset", {28'b0, rows}, 32'hF);
    check("dout_mid_reset", dout, 32'h0);
    exp_q.delete();
    exp_ovf = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(48);
    bus_read(ST, d);
    check("midreset_before_push", d, 32'h0);
`ifdef KEYPAD_IRQ_EN
    check("irq_before_rise", {31'b0, irq}, 32'h0);
`endif
    model_push(32'h19);
    status_check("midreset_after_push");
`ifdef KEYPAD_IRQ_EN
    check("irq_rise", {31'b0, irq}, 32'h1);
`endif
    keys = '0;
    data_check("midreset_data");
    tick(1);
`ifdef KEYPAD_IRQ_EN
    check("irq_fall", {31'b0, irq}, 32'h0);
`endif
    status_check("midreset_drained");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
